// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - single-issue sequencer feeding an 8-bit ALU, with a 4x8 register file, flags and a result channel
// Optional retired/illegal counters are compiled in with ALU_ISSUE_SEQ_PERF_EN.
module alu_issue_seq #(
    parameter logic [7:0] REG_RST_VAL      = 8'h00,
    parameter bit         STALL_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic [3:0]  alu_opcode,
    output logic [2:0]  alu_shift_amt,
    input  logic [7:0]  alu_res,
    input  logic        alu_cout,
    input  logic        alu_zero,
    input  logic        alu_sign,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_res,
    output logic [3:0]  out_flags,
    output logic        out_illegal,
    output logic [3:0]  flags
`ifdef ALU_ISSUE_SEQ_PERF_EN
    ,
    output logic [15:0] retired_cnt,
    output logic [7:0]  illegal_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  regs [4];
    logic [15:0] ir;
    logic        halt;
    logic [7:0]  res_q;
    logic [3:0]  oflags_q;
    logic        ill_q;

    logic [3:0]  op;
    logic [1:0]  rd;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic        is_arith;
    logic        is_logic;
    logic        is_shift;
    logic        is_ldi;
    logic        is_ill;
    logic        wr_en;
    logic [7:0]  wr_val;
    logic [3:0]  flags_nxt;

    assign op = ir[15:12];
    assign rd = ir[11:10];
    assign ra = ir[9:8];
    assign rb = ir[7:6];

    assign is_arith = (op == 4'h0) || (op == 4'h1) || (op == 4'h6) || (op == 4'h7);
    assign is_logic = (op >= 4'h2) && (op <= 4'h5);
    assign is_shift = (op[3:2] == 2'b10);
    assign is_ldi   = (op == 4'hC);
    assign is_ill   = (op >= 4'hD);

    assign out_res     = res_q;
    assign out_flags   = oflags_q;
    assign out_illegal = ill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        alu_a         = 8'h00;
        alu_b         = 8'h00;
        alu_cin       = 1'b0;
        alu_opcode    = 4'h0;
        alu_shift_amt = 3'd0;
        unique case (state)
            IDLE: begin
                in_ready = !halt;
                if (in_valid && !halt) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                alu_a         = regs[ra];
                alu_b         = regs[rb];
                alu_cin       = ir[2] ? flags[3] : 1'b0;
                alu_opcode    = op;
                alu_shift_amt = ir[5:3];
                state_nxt     = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write-back value and flag merge per opcode class; flags are {C,V,S,Z}.
    always_comb begin
        wr_en     = 1'b0;
        wr_val    = alu_res;
        flags_nxt = flags;
        if (is_arith) begin
            wr_en     = 1'b1;
            flags_nxt = {alu_cout, alu_overflow, alu_sign, alu_zero};
        end else if (is_logic) begin
            wr_en     = 1'b1;
            flags_nxt = {flags[3], 1'b0, alu_sign, alu_zero};
        end else if (is_shift) begin
            wr_en     = 1'b1;
            flags_nxt = {flags[3:2], alu_sign, alu_zero};
        end else if (is_ldi) begin
            wr_en     = 1'b1;
            wr_val    = ir[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= REG_RST_VAL;
            end
            flags    <= 4'h0;
            halt     <= 1'b0;
            ir       <= 16'h0000;
            res_q    <= 8'h00;
            oflags_q <= 4'h0;
            ill_q    <= 1'b0;
        end else begin
            if (state == IDLE && in_valid && in_ready) begin
                ir <= in_instr;
            end
            if (state == EXEC) begin
                if (wr_en) begin
                    regs[rd] <= wr_val;
                end
                flags    <= flags_nxt;
                res_q    <= wr_en ? wr_val : 8'h00;
                oflags_q <= flags_nxt;
                ill_q    <= is_ill;
                if (is_ill && STALL_ON_ILLEGAL) begin
                    halt <= 1'b1;
                end
            end
        end
    end

`ifdef ALU_ISSUE_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= 16'h0000;
            illegal_cnt <= 8'h00;
        end else if (out_valid && out_ready) begin
            if (retired_cnt != 16'hFFFF) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
            if (ill_q && illegal_cnt != 8'hFF) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - randomized self-checking bench for alu_issue_seq against an instruction-level model
module tb_alu_issue_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [15:0] in_instr;
    logic [7:0]  alu_a, alu_b, alu_res, out_res;
    logic        alu_cin, alu_cout, alu_zero, alu_sign, alu_overflow;
    logic [3:0]  alu_opcode, out_flags, flags;
    logic [2:0]  alu_shift_amt;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_illegal;
    logic [15:0] s_in_instr;
    logic [7:0]  s_alu_a, s_alu_b, s_alu_res, s_out_res;
    logic        s_alu_cin, s_alu_cout, s_alu_zero, s_alu_sign, s_alu_overflow;
    logic [3:0]  s_alu_opcode, s_out_flags, s_flags;
    logic [2:0]  s_alu_shift_amt;

`ifdef ALU_ISSUE_SEQ_PERF_EN
    logic [15:0] retired_cnt, s_retired_cnt;
    logic [7:0]  illegal_cnt, s_illegal_cnt;
`endif

    // Reference 8-bit ALU: result, cout, zero, sign, overflow.
    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                          input logic [3:0] op, input logic [2:0] sh);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'h0: begin w = {1'b0, a} + {1'b0, b} + {8'd0, cin}; r = w[7:0]; c = w[8];
                        v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'h1: begin w = {1'b0, a} - {1'b0, b} - {8'd0, cin}; r = w[7:0]; c = w[8];
                        v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'h2: begin r = a & b; c = a[0]; v = 1'b1; end
            4'h3: begin r = a | b; c = a[0]; v = 1'b1; end
            4'h4: begin r = a ^ b; c = a[0]; v = 1'b1; end
            4'h5: begin r = ~a;    c = a[0]; v = 1'b1; end
            4'h6: begin w = {1'b0, a} + 9'd1; r = w[7:0]; c = w[8]; v = (a == 8'h7F); end
            4'h7: begin w = {1'b0, a} - 9'd1; r = w[7:0]; c = w[8]; v = (a == 8'h80); end
            4'h8: begin r = a << sh; c = a[7]; v = a[0]; end
            4'h9: begin r = a >> sh; c = a[7]; v = a[0]; end
            4'hA: begin r = (a << sh) | (a >> (4'd8 - {1'b0, sh})); c = a[7]; v = a[0]; end
            4'hB: begin r = (a >> sh) | (a << (4'd8 - {1'b0, sh})); c = a[7]; v = a[0]; end
            default: begin r = a ^ b; c = 1'b1; v = 1'b1; end
        endcase
        return {r, c, (r == 8'd0), r[7], v};
    endfunction

    assign {alu_res, alu_cout, alu_zero, alu_sign, alu_overflow} =
        alu_f(alu_a, alu_b, alu_cin, alu_opcode, alu_shift_amt);
    assign {s_alu_res, s_alu_cout, s_alu_zero, s_alu_sign, s_alu_overflow} =
        alu_f(s_alu_a, s_alu_b, s_alu_cin, s_alu_opcode, s_alu_shift_amt);

    alu_issue_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
        .alu_shift_amt(alu_shift_amt), .alu_res(alu_res), .alu_cout(alu_cout),
        .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_flags(out_flags), .out_illegal(out_illegal), .flags(flags)
`ifdef ALU_ISSUE_SEQ_PERF_EN
        , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
    );

    alu_issue_seq #(.REG_RST_VAL(8'h00), .STALL_ON_ILLEGAL(1'b1)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_instr(s_in_instr),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_cin(s_alu_cin), .alu_opcode(s_alu_opcode),
        .alu_shift_amt(s_alu_shift_amt), .alu_res(s_alu_res), .alu_cout(s_alu_cout),
        .alu_zero(s_alu_zero), .alu_sign(s_alu_sign), .alu_overflow(s_alu_overflow),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_res(s_out_res),
        .out_flags(s_out_flags), .out_illegal(s_out_illegal), .flags(s_flags)
`ifdef ALU_ISSUE_SEQ_PERF_EN
        , .retired_cnt(s_retired_cnt), .illegal_cnt(s_illegal_cnt)
`endif
    );

    int total = 0;
    int bad = 0;
    logic [7:0] mr [4];
    logic [3:0] mf;
    int retired = 0;
    int illegals = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        mf = 4'h0;
        retired = 0;
        illegals = 0;
    endtask

    task automatic run_instr(input logic [15:0] ins, input int hold, input bit abort);
        logic [3:0]  op;
        logic [1:0]  rd, ra, rb;
        logic [7:0]  a, b, eres;
        logic        cin, eill, fc, fz, fs, fv;
        logic [11:0] f;
        int          n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(in_ready), 32'd1);
        op = ins[15:12]; rd = ins[11:10]; ra = ins[9:8]; rb = ins[7:6];
        a = mr[ra]; b = mr[rb];
        cin = ins[2] ? mf[3] : 1'b0;
        f = alu_f(a, b, cin, op, ins[5:3]);
        {eres, fc, fz, fs, fv} = f;
        eill = 1'b0;
        if (op inside {4'h0, 4'h1, 4'h6, 4'h7}) begin
            mr[rd] = eres; mf = {fc, fv, fs, fz};
        end else if (op <= 4'h5) begin
            mr[rd] = eres; mf = {mf[3], 1'b0, fs, fz};
        end else if (op <= 4'hB) begin
            mr[rd] = eres; mf = {mf[3:2], fs, fz};
        end else if (op == 4'hC) begin
            eres = ins[7:0]; mr[rd] = eres;
        end else begin
            eres = 8'h00; eill = 1'b1;
        end

        in_valid = 1'b1; in_instr = ins; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_instr = 16'($urandom);
        check("exec_out_valid", 32'(out_valid), 32'd0);
        check("exec_in_ready", 32'(in_ready), 32'd0);
        check("alu_a", 32'(alu_a), 32'(a));
        check("alu_b", 32'(alu_b), 32'(b));
        check("alu_cin", 32'(alu_cin), 32'(cin));
        check("alu_opcode", 32'(alu_opcode), 32'(op));
        check("alu_shift_amt", 32'(alu_shift_amt), 32'(ins[5:3]));
        @(negedge clk);
        for (int k = 0; k <= hold; k++) begin
            check("resp_valid", 32'(out_valid), 32'd1);
            check("out_res", 32'(out_res), 32'(eres));
            check("out_flags", 32'(out_flags), 32'(mf));
            check("out_illegal", 32'(out_illegal), 32'(eill));
            check("live_flags", 32'(flags), 32'(mf));
            check("resp_in_ready", 32'(in_ready), 32'd0);
            check("resp_alu_idle", 32'({alu_a, alu_opcode}), 32'd0);
            if (k < hold) @(negedge clk);
        end
        if (abort) begin
            #2 rst = 1'b1;
            #1;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_flags", 32'(flags), 32'd0);
            check("rst_out_res", 32'(out_res), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            rst = 1'b0;
            model_reset();
        end else begin
            out_ready = 1'b1;
            retired++;
            if (eill) illegals++;
            @(negedge clk);
            out_ready = 1'b0;
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_instr = 16'h0000; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_instr = 16'h0000; s_out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        check("reset_outs", 32'({out_res, out_flags, out_illegal}), 32'd0);
        check("reset_alu", 32'({alu_a, alu_b, alu_cin, alu_opcode, alu_shift_amt}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
`ifdef ALU_ISSUE_SEQ_PERF_EN
        check("retired_after_rst", 32'(retired_cnt), 32'd0);
`endif
        run_instr(16'hC00A, 0, 1'b0);
        run_instr(16'hC405, 0, 1'b0);
        run_instr(16'h0840, 0, 1'b0);
`ifdef ALU_ISSUE_SEQ_PERF_EN
        check("retired_three", 32'(retired_cnt), 32'd3);
`endif
        run_instr(16'h1D00, 0, 1'b0);
        run_instr(16'h0FC0, 0, 1'b0);
        run_instr(16'hC0AA, 0, 1'b0);
        run_instr(16'h8408, 0, 1'b0);
        run_instr(16'h0840, 5, 1'b0);
        run_instr(16'hF000, 0, 1'b0);
        run_instr(16'h0840, 0, 1'b0);

        // Sticky halt on the stalling instance.
        s_out_ready = 1'b1;
        check("s_ready_before", 32'(s_in_ready), 32'd1);
        s_in_valid = 1'b1; s_in_instr = 16'hF000;
        @(negedge clk);
        s_in_valid = 1'b0;
        @(negedge clk);
        check("s_out_illegal", 32'(s_out_illegal), 32'd1);
        check("s_out_res", 32'(s_out_res), 32'd0);
        s_in_valid = 1'b1; s_in_instr = 16'h0840;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("s_halt_ready", 32'(s_in_ready), 32'd0);
            check("s_halt_valid", 32'(s_out_valid), 32'd0);
        end
        s_in_valid = 1'b0;

        for (int i = 0; i < 150; i++) begin
            run_instr(16'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end
`ifdef ALU_ISSUE_SEQ_PERF_EN
        check("retired_cnt", 32'(retired_cnt), 32'(retired));
        check("illegal_cnt", 32'(illegal_cnt), 32'(illegals));
`endif

        run_instr(16'hC001, 0, 1'b0);
        run_instr(16'hC402, 0, 1'b0);
        run_instr(16'h1C40, 2, 1'b1);
        check("s_ready_after_rst", 32'(s_in_ready), 32'd1);
`ifdef ALU_ISSUE_SEQ_PERF_EN
        check("retired_after_rst2", 32'(retired_cnt), 32'd0);
`endif
        run_instr(16'h0EC0, 0, 1'b0);
        run_instr(16'h0840, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Single-issue sequencer that sits directly upstream of eightbit_alu.
- Accepts 16-bit instruction words over a valid/ready channel and reads operands from a 4-entry 8-bit register file.
- Drives the ALU operand/opcode inputs for one cycle, then captures res/cout/zero/sign/overflow.
- Writes the result back to the register file, maintains a C/V/S/Z flag register, and returns each result over a valid/ready channel.

Parameters:
- REG_RST_VAL, 8'h00: reset value of all four registers r0..r3.
- STALL_ON_ILLEGAL, 0: when 1, an illegal opcode sets a sticky halt and in_ready stays 0 until reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  sequencer can accept an instruction.
- in_instr  in  16  [15:12] opcode, [11:10] rd, [9:8] ra, [7:6] rb, [5:3] shift_amt, [2] use_carry, [1:0] reserved; for LDI, [7:0] is imm8.
- alu_a  out  8  ALU operand a.
- alu_b  out  8  ALU operand b.
- alu_cin  out  1  ALU carry-in.
- alu_opcode  out  4  ALU opcode.
- alu_shift_amt  out  3  ALU shift amount.
- alu_res  in  8  ALU result.
- alu_cout  in  1  ALU carry out.
- alu_zero  in  1  ALU zero flag.
- alu_sign  in  1  ALU sign flag.
- alu_overflow  in  1  ALU overflow flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  8  written-back value (imm8 for LDI, 0 for illegal).
- out_flags  out  4  flag register after this instruction, {C,V,S,Z}.
- out_illegal  out  1  the instruction had an illegal opcode.
- flags  out  4  live flag register {C,V,S,Z}.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset: state=IDLE, r0..r3=REG_RST_VAL, flags=0, halt=0. Every output is 0 except in_ready=1.
- IDLE:
  - in_ready=1 unless halt is set.
  - On in_valid&&in_ready, latch in_instr into ir and go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_a=r[ra], alu_b=r[rb], alu_opcode=ir[15:12], alu_shift_amt=ir[5:3], alu_cin=use_carry?C:0.
  - At the clock edge: write r[rd], update flags, register out_res/out_flags/out_illegal, go to RESP.
  - Operands are read before the write, so rd==ra or rd==rb is legal.
- ALU outputs are 0 in every state except EXEC.
- RESP:
  - out_valid=1. out_res, out_flags and out_illegal stay stable until out_ready.
  - On out_ready go to IDLE. in_ready rises on the following cycle.
- Latency and throughput: 1 cycle from accept to EXEC; out_valid asserts on the 2nd cycle after accept. Maximum throughput is one instruction per 3 cycles.
- in_ready=0 in EXEC and RESP.
- Opcode classes and flag updates:
  - 0000, 0001, 0110, 0111 (add/sub/inc/dec): write back; update C,V,S,Z from the ALU.
  - 0010 to 0101 (logic): write back; update S,Z; clear V; hold C.
  - 1000 to 1011 (shift/rotate): write back; update S,Z; hold C,V.
  - 1100 (LDI): r[rd]=imm8. The ALU is still driven but ignored. Flags unchanged.
  - 1101 to 1111 (illegal): no register or flag change; out_res=0, out_illegal=1; sets halt if STALL_ON_ILLEGAL=1.
- Reserved bits [1:0] are ignored.
- rst asserted in any state (including mid-EXEC or during RESP with out_ready low) returns immediately to reset values. The instruction in flight is lost.

Optional Feature:
- Macro: ALU_ISSUE_SEQ_PERF_EN.
- With the macro defined:
  - Adds output retired_cnt[15:0]: increments on each out_valid&&out_ready handshake, saturates at 16'hFFFF, resets to 0.
  - Adds output illegal_cnt[7:0]: increments on each accepted illegal handshake, saturates at 8'hFF, resets to 0.
- Without the macro: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Setup: the bench connects eightbit_alu, holds out_ready=1, and drives 0xC00A (LDI r0=10) then 0xC405 (LDI r1=5); ADD 0x0840 (r2=r0+r1).
  - Required: out_res=15, S=0, Z=0, V=0, C=alu_cout; out_valid appears 2 cycles after accept.
- SUB 0x1D00 (r3=r1-r0) -> out_res=8'hFB, S=1, Z=0; r3 reads back 251 via a following ADD r3+r3 with r=0 check skipped.
- LDI r0=0xAA (0xC0AA), then LSL 0x8408 (r1=r0<<1) -> out_res=8'h54, S=0, Z=0; C and V equal their values before the shift.
- Backpressure: hold out_ready=0 for 5 cycles in RESP -> out_valid=1 with stable out_res/out_flags and in_ready=0 throughout; release -> handshake, in_ready=1 on the next cycle.
- Illegal opcode 0xF000 -> out_illegal=1, out_res=0, registers and flags unchanged.
  - With STALL_ON_ILLEGAL=1: in_ready stays 0 until rst, then returns to 1.
- Assert rst during RESP -> out_valid=0 and flags=0 immediately, without waiting for a clock edge; r0..r3=REG_RST_VAL.
  - With ALU_ISSUE_SEQ_PERF_EN: retired_cnt=0 after rst and 3 after three handshakes.
